// File: rtl/pe_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// pe_seq_ctrl_if : scheduler / PE-row / memory / writeback signals of the
//                  SNN processing-element row sequencer.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pe_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int TAP_W  = 4,
  parameter int OUT_W  = 8
);
  logic              start;
  logic              abort;
  logic              cfg_mode;
  logic [TAP_W-1:0]  cfg_num_taps;
  logic [OUT_W-1:0]  cfg_num_out;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [7:0]        cfg_vth;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              pe_mode;
  logic              pe_accum_src;
  logic [7:0]        pe_vth;
  logic              pe_tap_valid;
  logic [OUT_W-1:0]  neuron_idx;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output start, abort, cfg_mode, cfg_num_taps, cfg_num_out, cfg_base_addr,
           cfg_vth, res_ready,
    input  busy, done, mem_rd_en, mem_addr, pe_mode, pe_accum_src, pe_vth,
           pe_tap_valid, neuron_idx, res_valid
  );

  modport slave (
    input  start, abort, cfg_mode, cfg_num_taps, cfg_num_out, cfg_base_addr,
           cfg_vth, res_ready,
    output busy, done, mem_rd_en, mem_addr, pe_mode, pe_accum_src, pe_vth,
           pe_tap_valid, neuron_idx, res_valid
  );
endinterface

`default_nettype wire

// File: rtl/pe_seq_ctrl.sv
//------------------------------------------------------------------------------
// pe_seq_ctrl : per-neuron sequencer for one SNN PE row (prime, stream taps,
//               drain pipeline, hand result to writeback).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_seq_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int TAP_W     = 4,
  parameter int OUT_W     = 8,
  parameter int DRAIN_CYC = 2
) (
  input  logic         clk,
  input  logic         nrst,
  pe_seq_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam int              DC_W       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_mode;
  logic [7:0]        r_vth;
  logic [TAP_W-1:0]  r_num_taps;
  logic [OUT_W-1:0]  r_num_out;
  logic [ADDR_W-1:0] r_addr;
  logic [TAP_W-1:0]  r_tap_cnt;
  logic [DC_W-1:0]   r_drain_cnt;
  logic [OUT_W-1:0]  r_idx;
  logic              r_tap_valid;

  logic w_start_go;
  logic w_last_tap;
  logic w_last_drain;
  logic w_last_out;
  logic w_handshake;
  logic w_busy;
  logic w_done;
  logic w_rd_en;
  logic w_accum_src;
  logic w_res_valid;

  // abort also masks a start in IDLE so the config is not latched
  assign w_start_go   = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_last_tap   = (r_tap_cnt == r_num_taps - TAP_W'(1));
  assign w_last_drain = (r_drain_cnt == DRAIN_LAST);
  assign w_last_out   = (r_idx == r_num_out - OUT_W'(1));
  assign w_handshake  = (r_state == S_OUT) && bus.res_ready && !bus.abort;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = (bus.cfg_num_out == '0) ? S_FIN : S_PRIME;
      S_PRIME:  w_next = (r_num_taps != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN:  if (w_last_drain) w_next = S_OUT;
      S_OUT:    if (bus.res_ready) w_next = w_last_out ? S_FIN : S_PRIME;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (bus.abort) begin
      w_next = S_IDLE;
    end
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_done      = (r_state == S_FIN);
    w_rd_en     = (r_state == S_STREAM);
    w_accum_src = (r_state == S_PRIME);
    w_res_valid = (r_state == S_OUT);
  end

  // address counter runs on across neurons; only a new start reloads it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode      <= 1'b0;
      r_vth       <= '0;
      r_num_taps  <= '0;
      r_num_out   <= '0;
      r_addr      <= '0;
      r_tap_cnt   <= '0;
      r_drain_cnt <= '0;
      r_idx       <= '0;
      r_tap_valid <= 1'b0;
    end else begin
      r_tap_valid <= (r_state == S_STREAM);
      case (r_state)
        S_IDLE: begin
          if (w_start_go) begin
            r_mode     <= bus.cfg_mode;
            r_vth      <= bus.cfg_vth;
            r_num_taps <= bus.cfg_num_taps;
            r_num_out  <= bus.cfg_num_out;
            r_addr     <= bus.cfg_base_addr;
            r_idx      <= '0;
          end
        end
        S_PRIME: begin
          r_tap_cnt   <= '0;
          r_drain_cnt <= '0;
        end
        S_STREAM: begin
          r_addr    <= r_addr + ADDR_W'(1);
          r_tap_cnt <= r_tap_cnt + TAP_W'(1);
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + DC_W'(1);
        end
        S_OUT: begin
          if (w_handshake && !w_last_out) begin
            r_idx <= r_idx + OUT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.mem_rd_en    = w_rd_en;
  assign bus.mem_addr     = r_addr;
  assign bus.pe_mode      = r_mode;
  assign bus.pe_accum_src = w_accum_src;
  assign bus.pe_vth       = r_vth;
  assign bus.pe_tap_valid = r_tap_valid;
  assign bus.neuron_idx   = r_idx;
  assign bus.res_valid    = w_res_valid;

endmodule

`default_nettype wire
